hub75_scanner: RTL

HUB75_SCANNER -- requirements
Module: hub75_scanner

---
 rtl/hub75_pkg.sv | 36 +++
 rtl/hub75_plane_mux.sv | 27 ++
 rtl/hub75_scanner.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/hub75_pkg.sv
// Shared types and constants for the HUB75 panel scanner: FSM states, per-channel
// bit positions inside a 9-bit pixel, and the bit-plane count.
package hub75_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      WAIT_DATA = 3'd1,
      SHIFT     = 3'd2,
      BLANK     = 3'd3,
      LATCH     = 3'd4,
      DISPLAY   = 3'd5
   } hub75_state_t;

   localparam int CH_BITS    = 3;
   localparam int NUM_PLANES = 3;
   localparam int PIX_BITS   = CH_BITS * NUM_PLANES;
   localparam int PLANE_W    = 2;
   localparam int R_LSB      = 6;
   localparam int G_LSB      = 3;
   localparam int B_LSB      = 0;

   // Bit `plane` of the channel whose LSB sits at `lsb`; unused plane codes read as 0.
   function automatic logic chan_bit(input logic [PIX_BITS-1:0] px,
                                     input int unsigned          lsb,
                                     input logic [PLANE_W-1:0]   plane);
      logic [CH_BITS-1:0] ch;
      ch = CH_BITS'(px >> lsb);
      case (plane)
         2'd0:    return ch[0];
         2'd1:    return ch[1];
         2'd2:    return ch[2];
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/hub75_plane_mux.sv
// Combinational bit-plane selector: picks the six serial data bits (upper and lower
// half, R/G/B each) of one pixel pair for a given plane.
module hub75_plane_mux
   import hub75_pkg::*;
(
   input  logic [PIX_BITS-1:0] upper,
   input  logic [PIX_BITS-1:0] lower,
   input  logic [PLANE_W-1:0]  plane,
   output logic                r0,
   output logic                g0,
   output logic                b0,
   output logic                r1,
   output logic                g1,
   output logic                b1
);

   // Slice each channel of both pixels at the requested plane.
   always_comb begin
      r0 = chan_bit(upper, R_LSB, plane);
      g0 = chan_bit(upper, G_LSB, plane);
      b0 = chan_bit(upper, B_LSB, plane);
      r1 = chan_bit(lower, R_LSB, plane);
      g1 = chan_bit(lower, G_LSB, plane);
      b1 = chan_bit(lower, B_LSB, plane);
   end

endmodule

// File: rtl/hub75_scanner.sv
// HUB75 panel scanner: captures one column pair, shifts it out as three binary-weighted
// bit planes (shift, blank, latch, display), then requests the next pair.
module hub75_scanner
   import hub75_pkg::*;
#(
   parameter int NUM_ROWS     = 64,
   parameter int SCAN_RATE    = 32,
   parameter int RGB_RES      = 9,
   parameter int BASE_DISPLAY = 16
)(
   input  logic                                   clk_in,
   input  logic                                   rst_in,
   input  logic [1:0][NUM_ROWS-1:0][RGB_RES-1:0]  columns,
   input  logic [$clog2(SCAN_RATE)-1:0]           col_num1,
   input  logic                                   data_valid,
   output logic                                   hub75_ready,
   output logic                                   r0,
   output logic                                   g0,
   output logic                                   b0,
   output logic                                   r1,
   output logic                                   g1,
   output logic                                   b1,
   output logic [$clog2(SCAN_RATE)-1:0]           addr,
   output logic                                   clk_out,
   output logic                                   lat,
   output logic                                   oe
);

   localparam int ADDR_W = $clog2(SCAN_RATE);
   localparam int PIX_W  = $clog2(NUM_ROWS);
   localparam int DISP_W = $clog2((BASE_DISPLAY << 2) + 1);

   hub75_state_t                          state_r;
   logic [PLANE_W-1:0]                    plane_r;
   logic [PIX_W-1:0]                      pix_r;
   logic                                  phase_r;
   logic [DISP_W-1:0]                     disp_cnt_r;
   logic [1:0][NUM_ROWS-1:0][RGB_RES-1:0] cap_r;
   logic [ADDR_W-1:0]                     cap_addr_r;

   logic [PIX_W-1:0]   sel_pix_s;
   logic [PLANE_W-1:0] sel_plane_s;
   logic [RGB_RES-1:0] upper_s;
   logic [RGB_RES-1:0] lower_s;
   logic [DISP_W-1:0]  disp_last_s;
   logic               m_r0_s, m_g0_s, m_b0_s, m_r1_s, m_g1_s, m_b1_s;
   logic [5:0]         bits_s;

   // Data for the pixel/plane about to be driven: the incoming pair on capture,
   // the next pixel while shifting, pixel 0 of the next plane when display ends.
   always_comb begin
      sel_pix_s   = '0;
      sel_plane_s = plane_r;
      upper_s     = cap_r[0][0];
      lower_s     = cap_r[1][0];
      if (state_r == WAIT_DATA) begin
         sel_plane_s = '0;
         upper_s     = columns[0][0];
         lower_s     = columns[1][0];
      end else if (state_r == SHIFT) begin
         sel_pix_s = pix_r + PIX_W'(1);
         upper_s   = cap_r[0][sel_pix_s];
         lower_s   = cap_r[1][sel_pix_s];
      end else if (state_r == DISPLAY) begin
         sel_plane_s = plane_r + PLANE_W'(1);
      end else begin
         sel_plane_s = plane_r;
      end
   end

   hub75_plane_mux u_plane_mux (
      .upper (upper_s),
      .lower (lower_s),
      .plane (sel_plane_s),
      .r0    (m_r0_s),
      .g0    (m_g0_s),
      .b0    (m_b0_s),
      .r1    (m_r1_s),
      .g1    (m_g1_s),
      .b1    (m_b1_s)
   );

   assign bits_s      = {m_r0_s, m_g0_s, m_b0_s, m_r1_s, m_g1_s, m_b1_s};
   assign disp_last_s = (DISP_W'(BASE_DISPLAY) << plane_r) - DISP_W'(1);

   // Scan FSM; every panel output is registered and set on the transition into its state.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_r     <= IDLE;
         plane_r     <= '0;
         pix_r       <= '0;
         phase_r     <= 1'b0;
         disp_cnt_r  <= '0;
         cap_r       <= '0;
         cap_addr_r  <= '0;
         hub75_ready <= 1'b0;
         {r0, g0, b0, r1, g1, b1} <= 6'b000000;
         addr        <= '0;
         clk_out     <= 1'b0;
         lat         <= 1'b0;
         oe          <= 1'b1;
      end else begin
         case (state_r)
            IDLE: begin
               // Entered either from reset (ready low) or from DISPLAY (ready already set).
               if (!hub75_ready) begin
                  hub75_ready <= 1'b1;
               end else begin
                  hub75_ready <= 1'b0;
                  state_r     <= WAIT_DATA;
               end
            end
            WAIT_DATA: begin
               if (data_valid) begin
                  cap_r      <= columns;
                  cap_addr_r <= col_num1;
                  plane_r    <= '0;
                  pix_r      <= '0;
                  phase_r    <= 1'b0;
                  clk_out    <= 1'b0;
                  {r0, g0, b0, r1, g1, b1} <= bits_s;
                  state_r    <= SHIFT;
               end else begin
                  state_r <= WAIT_DATA;
               end
            end
            SHIFT: begin
               if (!phase_r) begin
                  clk_out <= 1'b1;
                  phase_r <= 1'b1;
               end else if (pix_r == PIX_W'(NUM_ROWS - 1)) begin
                  clk_out <= 1'b0;
                  phase_r <= 1'b0;
                  pix_r   <= '0;
                  addr    <= cap_addr_r;
                  state_r <= BLANK;
               end else begin
                  clk_out <= 1'b0;
                  phase_r <= 1'b0;
                  pix_r   <= sel_pix_s;
                  {r0, g0, b0, r1, g1, b1} <= bits_s;
               end
            end
            BLANK: begin
               lat     <= 1'b1;
               state_r <= LATCH;
            end
            LATCH: begin
               lat        <= 1'b0;
               oe         <= 1'b0;
               disp_cnt_r <= '0;
               state_r    <= DISPLAY;
            end
            DISPLAY: begin
               if (disp_cnt_r == disp_last_s) begin
                  oe         <= 1'b1;
                  disp_cnt_r <= '0;
                  if (plane_r == PLANE_W'(NUM_PLANES - 1)) begin
                     hub75_ready <= 1'b1;
                     state_r     <= IDLE;
                  end else begin
                     plane_r <= sel_plane_s;
                     pix_r   <= '0;
                     phase_r <= 1'b0;
                     {r0, g0, b0, r1, g1, b1} <= bits_s;
                     state_r <= SHIFT;
                  end
               end else begin
                  disp_cnt_r <= disp_cnt_r + DISP_W'(1);
               end
            end
            default: begin
               state_r     <= IDLE;
               hub75_ready <= 1'b0;
               clk_out     <= 1'b0;
               lat         <= 1'b0;
               oe          <= 1'b1;
            end
         endcase
      end
   end

endmodule
